// File: rtl/mult8_wb_host_pkg.sv
// rtl/mult8_wb_host_pkg.sv - register map, CTRL bit positions and sequencer states for mult8_wb_host
package mult8_wb_host_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_OPER   = 8'h04;
    localparam logic [7:0] REG_RESULT = 8'h08;
    localparam logic [7:0] REG_COUNT  = 8'h0C;

    // CTRL write bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 3;

    // CTRL read bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/mult8_host_seq.sv
// rtl/mult8_host_seq.sv - start/done initiator FSM with timeout, product capture and completion count
module mult8_host_seq
    import mult8_wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_start_req,
    input  logic        i_clr_req,
    input  logic        i_done_clr_req,
    input  logic        i_mul_done,
    input  logic [15:0] i_mul_product,
    output logic        o_mul_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_product,
    output logic [15:0] o_count
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_start;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_product;
    logic [15:0] r_count;

    // Clears are applied first so a completion in the same cycle overrides them.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state   <= ST_IDLE;
            r_timer   <= 16'h0;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_product <= 16'h0;
            r_count   <= 16'h0;
        end else begin
            r_start <= 1'b0;
            if (i_clr_req) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (i_done_clr_req) begin
                r_done <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start_req) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= 16'h0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mul_done) begin
                        r_product <= i_mul_product;
                        r_done    <= 1'b1;
                        r_count   <= r_count + 16'h1;
                        r_state   <= ST_IDLE;
                    end else if (r_timer == TIMER_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'h1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mul_start = r_start;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_product   = r_product;
    assign o_count     = r_count;

endmodule

// File: rtl/mult8_wb_host.sv
// rtl/mult8_wb_host.sv - Wishbone slave host for the 8x8 multiplier; MULT8_WB_HOST_IRQ_EN adds irq_o and CTRL irq_en
module mult8_wb_host
    import mult8_wb_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
`ifdef MULT8_WB_HOST_IRQ_EN
    output logic        irq_o,
`endif
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  mul_a_o,
    output logic [7:0]  mul_b_o,
    output logic        mul_start_o,
    input  logic        mul_done_i,
    input  logic [15:0] mul_product_i
);

    logic        r_ack;
    logic [31:0] r_dat;
    logic [7:0]  r_a;
    logic [7:0]  r_b;

    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic [7:0]  w_off;
    logic [31:0] w_rdata;
    logic        w_busy;
    logic        w_done;
    logic        w_err;
    logic [15:0] w_product;
    logic [15:0] w_count;
    logic        w_irq_en;
    logic        w_unused;

    // Blocking the hit during the ack cycle keeps a held strobe from being acked twice.
    assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
    assign w_wr  = w_hit & wbs_we_i;
    assign w_rd  = w_hit & ~wbs_we_i;
    assign w_off = wbs_adr_i[7:0];
    assign w_unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            REG_CTRL: begin
                w_rdata[STAT_BUSY]   = w_busy;
                w_rdata[STAT_DONE]   = w_done;
                w_rdata[STAT_ERR]    = w_err;
                w_rdata[CTRL_IRQ_EN] = w_irq_en;
            end
            REG_OPER:   w_rdata = {16'h0, r_b, r_a};
            REG_RESULT: w_rdata = {16'h0, w_product};
            REG_COUNT:  w_rdata = {16'h0, w_count};
            default:    w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0;
            r_a   <= 8'h0;
            r_b   <= 8'h0;
        end else begin
            r_ack <= w_hit;
            if (w_hit) begin
                r_dat <= w_rd ? w_rdata : 32'h0;
            end
            if (w_wr && (w_off == REG_OPER) && !w_busy) begin
                if (wbs_sel_i[0]) r_a <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) r_b <= wbs_dat_i[15:8];
            end
        end
    end

`ifdef MULT8_WB_HOST_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_off == REG_CTRL)) begin
                r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            r_irq <= r_irq_en & (w_done | w_err);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq_o    = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    mult8_host_seq #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_seq (
        .i_clk          (wb_clk_i),
        .i_resetn       (wb_rst_i),
        .i_start_req    (w_wr && (w_off == REG_CTRL) && wbs_dat_i[CTRL_START]),
        .i_clr_req      (w_wr && (w_off == REG_CTRL) && wbs_dat_i[CTRL_CLR]),
        .i_done_clr_req (w_rd && (w_off == REG_RESULT)),
        .i_mul_done     (mul_done_i),
        .i_mul_product  (mul_product_i),
        .o_mul_start    (mul_start_o),
        .o_busy         (w_busy),
        .o_done         (w_done),
        .o_err          (w_err),
        .o_product      (w_product),
        .o_count        (w_count)
    );

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign mul_a_o   = r_a;
    assign mul_b_o   = r_b;

endmodule

// File: doc/mult8_wb_host.md
Name: mult8_wb_host

Overview:
- Wishbone-slave host for the sequential 8x8 multiplier; this block is the initiator side of the multiplier's start/done handshake.
- Firmware writes the operands and a START bit. The block issues a one-cycle start, waits for done, captures the 16-bit product, and reports status.
- Sits in user_project_wrapper between the wbs_* bus and the multiplier core.

Parameters:
- BASE_ADDR, 32'h3000_0000: register window base; bits [31:8] are matched.
- TIMEOUT_CYCLES, 64: cycles in WAIT before the timeout error is flagged. Legal range 2..65535.

Ports:
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_i  in  1  reset. One clock; reset is synchronous and active-low (0 = reset).
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- mul_a_o  out  8  operand A to the multiplier.
- mul_b_o  out  8  operand B to the multiplier.
- mul_start_o  out  1  one-cycle start pulse.
- mul_done_i  in  1  one-cycle completion pulse from the multiplier.
- mul_product_i  in  16  product; valid while mul_done_i=1.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, mul_start_o=0, mul_a_o=0, mul_b_o=0. All registers and counters are 0. FSM enters IDLE.
- Address hit: cyc&stb&(adr[31:8]==BASE_ADDR[31:8]).
  - On a hit, ack is asserted exactly one cycle later, for one cycle.
  - No second ack until the strobe is seen again after the ack cycle.
  - A miss is never acked.
- Register map (offset = adr[7:0]):
  - 0x00 CTRL
    - Write: bit0 START (self-clearing), bit1 CLR (clears done and err).
    - Read: bit0 busy, bit1 done, bit2 err.
  - 0x04 OPER
    - [7:0]=A, [15:8]=B; sel[0] and sel[1] are honoured.
    - A write while busy is acked but ignored.
    - mul_a_o and mul_b_o are driven directly from this register.
  - 0x08 RESULT: [15:0] last product, read-only. A read clears done.
  - 0x0C COUNT: [15:0] completed multiplies, wraps 0xFFFF->0, read-only.
  - Other in-window offsets: acked, read 0, writes ignored.
- FSM states and transitions:
  - IDLE: a START write enters ISSUE.
  - ISSUE: mul_start_o=1 for exactly this cycle; go to WAIT and load timer=0.
  - WAIT: timer increments each cycle.
    - mul_done_i=1: capture product, done=1, COUNT+1, go to IDLE.
    - timer==TIMEOUT_CYCLES-1 with no done: err=1, go to IDLE.
- busy = (state != IDLE).
- Boundary conditions:
  - START while busy: ignored.
  - START with done or err set: clears both, then starts.
  - START and CLR written together: CLR applied, then start.
  - mul_done_i outside WAIT: ignored. This includes a late done after a timeout.
  - mul_done_i on the timeout cycle: done wins and err stays 0.
  - RESULT read in the same cycle done is set: done remains set, because the set takes priority.
  - Reset mid-operation: everything returns to IDLE and cleared; any in-flight done is ignored.

Optional Feature:
- Macro: MULT8_WB_HOST_IRQ_EN.
- With it defined:
  - Adds port irq_o, out, 1.
  - CTRL bit3 = irq_en (read/write).
  - irq_o = irq_en & (done | err), registered; reset value 0.
  - irq_o drops one cycle after done/err clears.
- Without it:
  - No irq_o port.
  - CTRL bit3 reads 0 and writes are ignored.

Decomposition:
- Package mult8_wb_host_pkg holds:
  - register offset localparams;
  - CTRL bit-position constants;
  - state enum typedef (IDLE, ISSUE, WAIT).
- One sub-module, mult8_host_seq: FSM, timeout timer, product capture and COUNT, with a start/clear request interface.
- Wishbone decode and the register file stay in the top.

Test Plan:
- Write OPER=0x00FF_0A0C, START; model returns done after 8 cycles with 0x0078 -> exactly one start pulse with A=0x0C, B=0x0A; RESULT=0x0078, CTRL done=1, COUNT=1; a RESULT read then clears done.
- START, never return done -> err=1 exactly 64 cycles after ISSUE; busy=0; a later done pulse leaves RESULT and COUNT unchanged.
- While busy, write OPER=0x0000_0303 and START -> both acked; mul_a_o/mul_b_o unchanged; only one start pulse total.
- Done pulse on the same cycle as timeout expiry -> done=1, err=0.
- Hold wb_rst_i=0 during WAIT, release, then inject done -> all outputs 0, state IDLE, done ignored.
- Access BASE_ADDR+0x10 and BASE_ADDR+0x100 -> the first is acked with data 0; the second gets no ack within 8 cycles.
